// File: rtl/memory_unit.sv
// Single-port RAM for the processor datapath: synchronous write from bus_1,
// asynchronous read of the addressed word onto mem_word.
module memory_unit #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] address,
   input  logic [DATA_WIDTH-1:0] bus_1,
   input  logic                  write,
   output logic [DATA_WIDTH-1:0] mem_word
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   // Reset clears every word and takes priority over a write on the same edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (write) begin
         mem[address] <= bus_1;
      end
   end

   // No bypass: a same-address write only becomes visible after the edge.
   assign mem_word = mem[address];

endmodule

// File: tb/tb_memory_unit.sv
// Directed bench for memory_unit: reset clear, writes, readback, boundaries,
// hold, read-during-write ordering and reset-over-write priority.
module tb_memory_unit;

   logic       clk;
   logic       rst;
   logic [7:0] address;
   logic [7:0] bus_1;
   logic       write;
   logic [7:0] mem_word;

   int tests_run;
   int tests_failed;

   memory_unit #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) dut (
      .clk      (clk),
      .rst      (rst),
      .address  (address),
      .bus_1    (bus_1),
      .write    (write),
      .mem_word (mem_word)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%02h, expected 0x%02h", tag, obs, exp);
      end
   endtask

   // One active edge, then settle away from it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_word(input logic [7:0] a, input logic [7:0] d);
      address = a;
      bus_1   = d;
      write   = 1'b1;
      tick();
      write   = 1'b0;
   endtask

   task automatic read_check(input string tag, input logic [7:0] a, input logic [7:0] exp);
      address = a;
      #1;
      check_val(tag, mem_word, exp);
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      rst     = 1'b1;
      write   = 1'b1;
      address = 8'h10;
      bus_1   = 8'h33;
      #2;
      tick();
      rst   = 1'b0;
      write = 1'b0;

      for (int a = 0; a < 256; a++) begin
         read_check("reset_sweep", 8'(a), 8'h00);
      end

      // Read-during-write: old value before the edge, new value right after.
      address = 8'h01;
      bus_1   = 8'h06;
      write   = 1'b1;
      #1;
      check_val("rdw_before_edge", mem_word, 8'h00);
      tick();
      check_val("rdw_after_edge", mem_word, 8'h06);
      write = 1'b0;
      read_check("rd_01", 8'h01, 8'h06);
      read_check("rd_00_untouched", 8'h00, 8'h00);

      write_word(8'h00, 8'h02);
      read_check("rd_00", 8'h00, 8'h02);
      read_check("rd_01_kept", 8'h01, 8'h06);
      read_check("toggle_00", 8'h00, 8'h02);
      read_check("toggle_01", 8'h01, 8'h06);

      write_word(8'hFF, 8'hA5);
      write_word(8'h00, 8'h5A);
      read_check("bound_ff", 8'hFF, 8'hA5);
      read_check("bound_00", 8'h00, 8'h5A);
      read_check("bound_01", 8'h01, 8'h06);
      read_check("bound_fe", 8'hFE, 8'h00);
      read_check("bound_7f", 8'h7F, 8'h00);
      read_check("bound_80", 8'h80, 8'h00);

      // Hold: bus_1 changes with write low must not disturb storage.
      address = 8'h01;
      bus_1   = 8'hFF;
      write   = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         check_val("hold_01", mem_word, 8'h06);
         bus_1 = bus_1 - 8'h11;
      end

      // rst between edges has no effect until the next edge; it beats write.
      rst     = 1'b1;
      write   = 1'b1;
      address = 8'h01;
      bus_1   = 8'h77;
      #1;
      check_val("rst_pending", mem_word, 8'h06);
      tick();
      check_val("rst_over_write", mem_word, 8'h00);
      rst   = 1'b0;
      write = 1'b0;
      read_check("rst_clr_00", 8'h00, 8'h00);
      read_check("rst_clr_ff", 8'hFF, 8'h00);
      read_check("rst_clr_01", 8'h01, 8'h00);

      write_word(8'h42, 8'hC3);
      read_check("post_rst_wr", 8'h42, 8'hC3);
      read_check("post_rst_43", 8'h43, 8'h00);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
